// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared types, defaults and LFSR step for the mole round scheduler
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          SLOTS_DEF       = 9;
  localparam int          LIFE_DEF        = 3;
  localparam int          MAX_ACTIVE_DEF  = 3;
  localparam int          ROUND_TICKS_DEF = 30;
  localparam int          TARGET_DEF      = 10;
  localparam logic [15:0] SEED_DEF        = 16'hACE1;

  // Right-shifting Fibonacci step; the feedback bit enters at bit 15.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

endpackage

// File: rtl/mole_round_scheduler_if.sv
// rtl/mole_round_scheduler_if.sv - game event and display bundle between scheduler and its neighbours
interface mole_round_scheduler_if
  import mole_pkg::*;
#(
  parameter int SLOTS = SLOTS_DEF
);
  logic             start;
  logic             tick;
  logic             hit_valid;
  logic [3:0]       hit_idx;
  logic [SLOTS-1:0] mole;
  logic [4:0]       score;
  logic [4:0]       time_left;
  state_t           state;
  logic             win;
  logic             hit_ok;
  logic             hit_miss;

  modport master (
    output start, tick, hit_valid, hit_idx,
    input  mole, score, time_left, state, win, hit_ok, hit_miss
  );

  modport slave (
    input  start, tick, hit_valid, hit_idx,
    output mole, score, time_left, state, win, hit_ok, hit_miss
  );
endinterface

// File: rtl/mole_lfsr16.sv
// rtl/mole_lfsr16.sv - free-running 16-bit LFSR used to pick spawn slots
module mole_lfsr16
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEF
)(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  // Advance every clock in every game state; only reset reloads the seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= SEED;
    else     value <= lfsr_next(value);
  end

endmodule

// File: rtl/mole_round_scheduler.sv
// rtl/mole_round_scheduler.sv - whack-a-mole round FSM, mole slot pool, score and countdown
module mole_round_scheduler
  import mole_pkg::*;
#(
  parameter int          SLOTS       = SLOTS_DEF,
  parameter int          LIFE        = LIFE_DEF,
  parameter int          MAX_ACTIVE  = MAX_ACTIVE_DEF,
  parameter int          ROUND_TICKS = ROUND_TICKS_DEF,
  parameter int          TARGET      = TARGET_DEF,
  parameter logic [15:0] SEED        = SEED_DEF
)(
  input logic                  clk,
  input logic                  rst,
  mole_round_scheduler_if.slave bus
);

  localparam int              LW       = $clog2(LIFE + 1);
  localparam int              CW       = $clog2(SLOTS + 1);
  localparam logic [4:0]      TARGET_V = 5'(TARGET);
  localparam logic [4:0]      ROUND_V  = 5'(ROUND_TICKS);
  localparam logic [LW-1:0]   LIFE_V   = LW'(LIFE);
  localparam logic [CW-1:0]   MAX_V    = CW'(MAX_ACTIVE);
  localparam logic [3:0]      SLOTS_V  = 4'(SLOTS);

  logic [15:0]      lfsr;
  logic             lfsr_unused;

  state_t           state_q;
  logic [SLOTS-1:0] mole_q;
  logic [LW-1:0]    life_q [SLOTS];
  logic [4:0]       score_q;
  logic [4:0]       time_q;
  logic             win_q;
  logic             ok_q;
  logic             miss_q;

  logic [SLOTS-1:0] mole_n;
  logic [LW-1:0]    life_n [SLOTS];
  logic [SLOTS-1:0] hit_clr;
  logic [4:0]       score_n;
  logic [4:0]       time_n;
  logic             ok_n;
  logic             miss_n;
  logic [CW-1:0]    live_cnt;
  logic [3:0]       cand;
  logic             end_win;
  logic             end_round;

  mole_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  // Only the low nibble picks a spawn slot; the rest of the LFSR state is unused here.
  assign lfsr_unused = ^lfsr[15:4];

  // One RUN cycle: hit, then aging, then spawn, then countdown, then end-of-round test.
  always_comb begin
    mole_n   = mole_q;
    life_n   = life_q;
    hit_clr  = '0;
    score_n  = score_q;
    time_n   = time_q;
    ok_n     = 1'b0;
    miss_n   = 1'b0;
    live_cnt = '0;
    cand     = (lfsr[3:0] >= SLOTS_V) ? (lfsr[3:0] - SLOTS_V) : lfsr[3:0];

    for (int i = 0; i < SLOTS; i++) begin
      if (bus.hit_valid && bus.hit_idx == 4'(i + 1)) begin
        if (mole_q[i]) begin
          mole_n[i]  = 1'b0;
          life_n[i]  = '0;
          hit_clr[i] = 1'b1;
          ok_n       = 1'b1;
        end else begin
          miss_n = 1'b1;
        end
      end
    end
    if (ok_n && score_n != TARGET_V) score_n = score_n + 5'd1;

    if (bus.tick) begin
      // A slot just cleared by the hit is already dead, so it is skipped here.
      for (int i = 0; i < SLOTS; i++) begin
        if (mole_n[i]) begin
          if (life_n[i] == LW'(1)) begin
            mole_n[i] = 1'b0;
            life_n[i] = '0;
          end else begin
            life_n[i] = life_n[i] - LW'(1);
          end
        end
      end
      for (int i = 0; i < SLOTS; i++) live_cnt = live_cnt + CW'(mole_n[i]);
      for (int i = 0; i < SLOTS; i++) begin
        if (cand == 4'(i) && !mole_n[i] && !hit_clr[i] && live_cnt < MAX_V) begin
          mole_n[i] = 1'b1;
          life_n[i] = LIFE_V;
        end
      end
      if (time_n != 5'd0) time_n = time_n - 5'd1;
    end

    end_win   = (score_n == TARGET_V);
    end_round = end_win || (time_n == 5'd0);
  end

  // Game FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mole_q  <= '0;
      for (int i = 0; i < SLOTS; i++) life_q[i] <= '0;
      score_q <= '0;
      time_q  <= ROUND_V;
      win_q   <= 1'b0;
      ok_q    <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      ok_q   <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            mole_q  <= '0;
            for (int i = 0; i < SLOTS; i++) life_q[i] <= '0;
            score_q <= '0;
            time_q  <= ROUND_V;
            win_q   <= 1'b0;
          end
        end
        RUN: begin
          ok_q    <= ok_n;
          miss_q  <= miss_n;
          score_q <= score_n;
          time_q  <= time_n;
          if (end_round) begin
            state_q <= DONE;
            mole_q  <= '0;
            for (int i = 0; i < SLOTS; i++) life_q[i] <= '0;
            win_q   <= end_win;
          end else begin
            mole_q <= mole_n;
            life_q <= life_n;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mole      = mole_q;
  assign bus.score     = score_q;
  assign bus.time_left = time_q;
  assign bus.state     = state_q;
  assign bus.win       = win_q;
  assign bus.hit_ok    = ok_q;
  assign bus.hit_miss  = miss_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// tb/tb_mole_round_scheduler.sv - self-checking bench for the mole round scheduler
module tb_mole_round_scheduler;

  localparam int NS   = 9;
  localparam int LIFE = 3;
  localparam int MAXA = 3;
  localparam int RT   = 30;
  localparam int TGT  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mole_round_scheduler_if #(.SLOTS(NS)) bus();

  mole_round_scheduler #(
    .SLOTS(NS), .LIFE(LIFE), .MAX_ACTIVE(MAXA), .ROUND_TICKS(RT), .TARGET(TGT), .SEED(16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: live moles as a list of (slot, ticks survived).
  typedef struct { int slot; int age; } live_t;
  live_t       q[$];
  int          m_state, m_score, m_time, m_win, m_ok, m_miss;
  logic [15:0] m_lfsr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit st; bit tk; bit hv; int hi;
    bit e_ok; bit e_miss; int e_score; int e_time; int e_state;
  } vec_t;
  vec_t vecs[7];

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int m_mask();
    int m = 0;
    foreach (q[i]) m |= (1 << q[i].slot);
    return m;
  endfunction

  function automatic int lowest_live();
    int m = m_mask();
    for (int s = 0; s < NS; s++) if (m[s]) return s;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_time = RT; m_win = 0; m_ok = 0; m_miss = 0;
    m_lfsr  = 16'hACE1;
    q.delete();
  endtask

  task automatic model_step(bit st, bit tk, bit hv, int hi);
    int v, c, hit_slot, idx, m;
    v = int'(m_lfsr[3:0]);
    m_ok = 0; m_miss = 0;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_score = 0; m_time = RT; m_win = 0; q.delete();
      end
    end else begin
      hit_slot = -1;
      if (hv && hi >= 1 && hi <= NS) begin
        idx = -1;
        foreach (q[i]) if (q[i].slot == hi - 1) idx = i;
        if (idx >= 0) begin
          q.delete(idx);
          m_score  = (m_score < TGT) ? m_score + 1 : TGT;
          m_ok     = 1;
          hit_slot = hi - 1;
        end else begin
          m_miss = 1;
        end
      end
      if (tk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          q[i].age = q[i].age + 1;
          if (q[i].age >= LIFE) q.delete(i);
        end
        c = (v >= NS) ? v - NS : v;
        m = m_mask();
        if (!m[c] && c != hit_slot && q.size() < MAXA) q.push_back('{c, 0});
        if (m_time > 0) m_time--;
      end
      if (m_score == TGT || m_time == 0) begin
        m_win = (m_score == TGT) ? 1 : 0;
        m_state = 2;
        q.delete();
      end
    end
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  task automatic compare_all();
    check("state",     int'(bus.state), m_state);
    check("score",     int'(bus.score), m_score);
    check("time_left", int'(bus.time_left), m_time);
    check("mole",      int'(bus.mole), m_mask());
    check("win",       int'(bus.win), m_win);
    check("hit_ok",    int'(bus.hit_ok), m_ok);
    check("hit_miss",  int'(bus.hit_miss), m_miss);
    check("ok_miss_exclusive", int'(bus.hit_ok & bus.hit_miss), 0);
    check("popcount_le_max", ($countones(bus.mole) <= MAXA) ? 1 : 0, 1);
  endtask

  task automatic drive(bit st, bit tk, bit hv, int hi);
    bus.start = st; bus.tick = tk; bus.hit_valid = hv; bus.hit_idx = 4'(hi);
    @(posedge clk);
    model_step(st, tk, hv, hi);
    #1;
    compare_all();
    bus.start = 1'b0; bus.tick = 1'b0; bus.hit_valid = 1'b0; bus.hit_idx = 4'd0;
  endtask

  task automatic check_reset(string pfx);
    check({pfx, "_state"}, int'(bus.state), 0);
    check({pfx, "_time"},  int'(bus.time_left), RT);
    check({pfx, "_score"}, int'(bus.score), 0);
    check({pfx, "_mole"},  int'(bus.mole), 0);
    check({pfx, "_win"},   int'(bus.win), 0);
    check({pfx, "_ok"},    int'(bus.hit_ok), 0);
    check({pfx, "_miss"},  int'(bus.hit_miss), 0);
  endtask

  initial begin
    int k, hi;
    bit st, tk, hv;

    bus.start = 1'b0; bus.tick = 1'b0; bus.hit_valid = 1'b0; bus.hit_idx = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("rst");

    // Idle with tick toggling: nothing may move.
    for (int i = 0; i < 100; i++) drive(1'b0, 1'(i % 2), 1'b0, 0);
    check("idle_hold_state", int'(bus.state), 0);
    check("idle_hold_time", int'(bus.time_left), RT);

    drive(1'b1, 1'b0, 1'b0, 0);
    check("start_run", int'(bus.state), 1);

    // Table of single-cycle events in RUN with no live moles.
    vecs[0] = '{1'b0, 1'b0, 1'b1, 4,  1'b0, 1'b1, 0, RT, 1};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b0, 0, RT, 1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b0, 0, RT, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0, 0, RT, 1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 9,  1'b0, 1'b1, 0, RT, 1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 0, RT, 1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 0, RT, 1};
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].st, vecs[i].tk, vecs[i].hv, vecs[i].hi);
      check($sformatf("vec%0d_ok", i),    int'(bus.hit_ok), int'(vecs[i].e_ok));
      check($sformatf("vec%0d_miss", i),  int'(bus.hit_miss), int'(vecs[i].e_miss));
      check($sformatf("vec%0d_score", i), int'(bus.score), vecs[i].e_score);
      check($sformatf("vec%0d_time", i),  int'(bus.time_left), vecs[i].e_time);
      check($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].e_state);
    end

    // Full round of 30 ticks with no hits.
    for (int t = 1; t <= RT; t++) begin
      drive(1'b0, 1'b1, 1'b0, 0);
      if (t == RT - 1) begin
        check("tick29_state", int'(bus.state), 1);
        check("tick29_time", int'(bus.time_left), 1);
      end
      if (t < RT) drive(1'b0, 1'b0, 1'b0, 0);
    end
    check("timeout_state", int'(bus.state), 2);
    check("timeout_time", int'(bus.time_left), 0);
    check("timeout_win", int'(bus.win), 0);
    check("timeout_mole", int'(bus.mole), 0);
    drive(1'b0, 1'b1, 1'b1, 1);
    check("done_no_pulse", int'(bus.hit_ok | bus.hit_miss), 0);

    // Winning round: hit every mole the cycle after it appears.
    drive(1'b1, 1'b0, 1'b0, 0);
    for (int it = 0; it < 40 && m_state == 1; it++) begin
      drive(1'b0, 1'b1, 1'b0, 0);
      k = lowest_live();
      if (k >= 0) drive(1'b0, 1'b0, 1'b1, k + 1);
    end
    check("win_state", int'(bus.state), 2);
    check("win_flag", int'(bus.win), 1);
    check("win_score", int'(bus.score), TGT);
    check("win_mole", int'(bus.mole), 0);

    // Hit landing on the same cycle as the mole's expiring tick.
    drive(1'b1, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    check("first_spawn", (bus.mole != 0) ? 1 : 0, 1);
    k = lowest_live();
    if (k < 0) k = 0;
    drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, k + 1);
    check("expire_hit_ok", int'(bus.hit_ok), 1);
    check("expire_hit_score", int'(bus.score), 1);
    check("expire_no_respawn", int'(bus.mole[k]), 0);

    // Build score 5 / time 12, then start-in-RUN and async reset.
    for (int it = 0; it < 40 && m_score < 5 && m_state == 1; it++) begin
      drive(1'b0, 1'b1, 1'b0, 0);
      k = lowest_live();
      if (k >= 0 && m_score < 5) drive(1'b0, 1'b0, 1'b1, k + 1);
    end
    for (int it = 0; it < 40 && m_time > 12 && m_state == 1; it++) drive(1'b0, 1'b1, 1'b0, 0);
    check("pre_rst_score", int'(bus.score), 5);
    check("pre_rst_time", int'(bus.time_left), 12);
    drive(1'b1, 1'b0, 1'b0, 0);
    check("start_in_run_score", int'(bus.score), 5);
    check("start_in_run_time", int'(bus.time_left), 12);
    check("start_in_run_state", int'(bus.state), 1);
    rst = 1'b1;
    #2;
    check_reset("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_reset("midrst_held");

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 63) == 0);
      tk = ($urandom_range(0, 3) == 0);
      hv = 1'($urandom_range(0, 1));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) hi = q[$urandom_range(0, q.size() - 1)].slot + 1;
      else hi = int'($urandom_range(0, 15));
      drive(st, tk, hv, hi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_round_scheduler.md
# mole_round_scheduler

Round controller for the LED whack-a-mole game. It owns the game state machine, the round countdown and score, and a pool of nine mole slots shown on LED[15:7]. On each game tick it ages the live moles and spawns new ones from an LFSR. It arbitrates decoded keypad hits against the live slots. It sits between the keyboard decoder (hit events), the 1 s tick divider, and the LED / 7-segment drivers.

## Interface
- SLOTS, 9, number of mole slots; LED[15-k] shows slot k.
- LIFE, 3, number of ticks a mole stays lit.
- MAX_ACTIVE, 3, maximum number of moles lit at once.
- ROUND_TICKS, 30, round length in ticks.
- TARGET, 10, score that wins the round.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse (debounced and one-pulsed upstream)
- tick  in  1  one-cycle game-tick pulse
- hit_valid  in  1  one-cycle key event
- hit_idx  in  4  key digit 0..9; digit d targets slot d-1
- mole  out  SLOTS  live-slot mask
- score  out  5  hits this round
- time_left  out  5  remaining ticks
- state  out  2  IDLE=0, RUN=1, DONE=2
- win  out  1  high in DONE when score==TARGET
- hit_ok, hit_miss  out  1  one-cycle result pulses

## Operation
- Reset values: state IDLE, mole 0, score 0, time_left ROUND_TICKS, win 0, hit_ok 0, hit_miss 0, all life counters 0, LFSR SEED.
- LFSR: 16-bit, advances every clk in all states: next = {l[0]^l[2]^l[3]^l[5], l[15:1]}. It is not reseeded by start.
- IDLE→RUN and DONE→RUN on start. On that edge: score 0, time_left ROUND_TICKS, mole 0, win 0. A start pulse while in RUN is ignored.
- RUN, evaluated in this order within one cycle:
  1. Hit. Applies only when hit_valid is high and hit_idx is 1..9. If slot k=hit_idx-1 is live, clear it, score+1, pulse hit_ok. Otherwise pulse hit_miss. hit_idx 0 or above 9 produces no pulse and no change.
  2. Tick aging. Each live slot decrements its life counter; a slot whose life is 1 clears. A slot already cleared by the hit in step 1 is not aged.
  3. Tick spawn. v=LFSR[3:0]; candidate c = (v≥9) ? v-9 : v. Spawn into c when c is free after steps 1–2, c was not cleared by a hit this cycle, and the live count after steps 1–2 is below MAX_ACTIVE. A spawned slot is set live with life LIFE. At most one spawn per tick; on a collision nothing spawns.
  4. Tick countdown: time_left-1.
- Go to DONE when the next score equals TARGET, or when the next time_left is 0. On that same edge mole is cleared and win is set to (next score==TARGET). A win takes priority when both conditions occur together.
- DONE and IDLE: hits and ticks are ignored (no pulses), and all outputs hold.
- score saturates at TARGET; time_left never goes below 0.

## Timing
- All outputs are registered. The effect of an event in cycle N is visible after edge N+1.
- hit_ok and hit_miss last exactly one cycle, never assert together, and only assert in RUN.
- A mole spawned at tick T is lit for exactly LIFE ticks: it clears at the LIFE-th following tick, unless it is hit first.
- A hit in the same cycle as the expiring tick scores.
- rst mid-RUN returns immediately to the reset values, with no pulse.

## Structure
- Package mole_pkg holds: the state enum (IDLE/RUN/DONE), the LFSR tap function, and the default parameter constants.
- One sub-module, mole_lfsr16 (clk, rst, SEED → 16-bit value), instantiated once.
- Per-slot life counters are held as an array of $clog2(LIFE+1)-bit registers.

## Test plan
- Reset with no stimulus → state 0, time_left 30, score 0, mole 0, no pulses for 100 cycles even while tick toggles.
- start, then 30 ticks with no hits → state DONE on the edge after the 30th tick, time_left 0, win 0, mole 0. Across the whole round, popcount(mole) ≤ 3 and every mole lasts exactly 3 ticks.
- RUN with mole 0 and hit_idx 4 → one-cycle hit_miss, score unchanged. hit_idx 0 or 12 → no pulse.
- Monitor mole and hit each lit slot k with hit_idx k+1 → hit_ok, mole[k] clears, score increments. The 10th hit → DONE, win 1, score 10 on the same edge.
- Hit on slot k in the same cycle as its expiring tick → score+1, hit_ok, and no spawn into slot k that cycle.
- Assert rst with score 5 and time_left 12 → all reset values next cycle. A start in RUN → no change to score or time_left.
